// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: EX->WB forwarding plus req/ack data-bus loads and stores
module mem_access_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       hi_i,
  input  logic [31:0]       lo_i,
  input  logic              whilo_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       store_data_i,
  output logic [31:0]       wdata_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o,
  output logic              whilo_o,
  output logic [ADDR_W-1:0] daddr_o,
  output logic [31:0]       dwdata_o,
  output logic [3:0]        dbe_o,
  output logic              dwe_o,
  output logic              dreq_o,
  input  logic              dack_i,
  input  logic [31:0]       drdata_i,
  output logic              stall_req_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              bus_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        is_load, is_store, is_half, is_word, misalign, go;
  logic [16:0] cnt_inc;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v, bus_wdata;
  logic [3:0]  bus_be;

  always_comb begin
    is_load  = (mem_op_i >= 4'd1) && (mem_op_i <= 4'd5);
    is_store = (mem_op_i >= 4'd6) && (mem_op_i <= 4'd8);
    is_half  = (mem_op_i == 4'd3) || (mem_op_i == 4'd4) || (mem_op_i == 4'd7);
    is_word  = (mem_op_i == 4'd5) || (mem_op_i == 4'd8);
    misalign = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
    go       = (is_load || is_store) && !misalign;
    cnt_inc  = {1'b0, cnt_q} + 17'd1;
  end

  // Timeout fires when the counter reaches TIMEOUT, so the access gets exactly TIMEOUT WAIT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (go) begin
        state_d = S_WAIT;
        cnt_d   = 16'd0;
        err_d   = 1'b0;
      end
      S_WAIT: begin
        cnt_d = cnt_inc[15:0];
        if (dack_i) begin
          rdata_d = drdata_i;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_inc == 17'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Big-endian lanes: byte address 0 lives in bits 31:24.
  always_comb begin
    unique case (mem_addr_i[1:0])
      2'd0:    byte_v = rdata_q[31:24];
      2'd1:    byte_v = rdata_q[23:16];
      2'd2:    byte_v = rdata_q[15:8];
      default: byte_v = rdata_q[7:0];
    endcase
    half_v = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
    unique case (mem_op_i)
      4'd1:    load_v = {{24{byte_v[7]}}, byte_v};
      4'd2:    load_v = {24'd0, byte_v};
      4'd3:    load_v = {{16{half_v[15]}}, half_v};
      4'd4:    load_v = {16'd0, half_v};
      default: load_v = rdata_q;
    endcase
    bus_wdata = 32'd0;
    bus_be    = 4'b1111;
    unique case (mem_op_i)
      4'd6: begin
        bus_wdata = {4{store_data_i[7:0]}};
        bus_be    = 4'b1000 >> mem_addr_i[1:0];
      end
      4'd7: begin
        bus_wdata = {2{store_data_i[15:0]}};
        bus_be    = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      end
      4'd8:    bus_wdata = store_data_i;
      default: bus_wdata = 32'd0;
    endcase
  end

  // While the access is in flight the stage presents a bubble to WB.
  always_comb begin
    wdata_o     = 32'd0;
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    hi_o        = 32'd0;
    lo_o        = 32'd0;
    whilo_o     = 1'b0;
    daddr_o     = '0;
    dwdata_o    = 32'd0;
    dbe_o       = 4'd0;
    dwe_o       = 1'b0;
    dreq_o      = 1'b0;
    stall_req_o = 1'b0;
    adel_o      = 1'b0;
    ades_o      = 1'b0;
    bus_err_o   = 1'b0;
    if (!rst) begin
      if ((state_q == S_IDLE && go) || state_q == S_WAIT) begin
        dreq_o      = 1'b1;
        stall_req_o = 1'b1;
        daddr_o     = {mem_addr_i[ADDR_W-1:2], 2'b00};
        dwdata_o    = bus_wdata;
        dbe_o       = bus_be;
        dwe_o       = is_store;
      end else if (state_q == S_DONE) begin
        wdata_o   = is_load ? load_v : wdata_i;
        wd_o      = wd_i;
        wreg_o    = wreg_i && !err_q;
        hi_o      = hi_i;
        lo_o      = lo_i;
        whilo_o   = whilo_i && !err_q;
        bus_err_o = err_q;
      end else begin
        wdata_o = wdata_i;
        wd_o    = wd_i;
        wreg_o  = wreg_i && !misalign;
        hi_o    = hi_i;
        lo_o    = lo_i;
        whilo_o = whilo_i && !misalign;
        adel_o  = is_load && misalign;
        ades_o  = is_store && misalign;
      end
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MIPS-style MEM pipeline stage, the successor to the passthrough MEM stage.
- Forwards EX results (GPR write, HI/LO write) to WB.
- Executes loads and stores over a req/ack data-memory bus with wait states, big-endian byte lanes, sign/zero extension and alignment checking.
- Stalls the pipeline via stall_req_o while a bus access is outstanding; sits between the EX/MEM and MEM/WB registers.

Parameters:
ADDR_W, 32, data-bus address width; mem_addr_i[1:0] selects the byte lane.
TIMEOUT, 255, max cycles waiting for dack_i before aborting with bus error; range 1..65535.

Ports:
clk  in  1  clock
rst  in  1  reset
wdata_i  in  32  EX result for GPR write
wd_i  in  5  destination register
wreg_i  in  1  GPR write enable
hi_i  in  32  HI value
lo_i  in  32  LO value
whilo_i  in  1  HI/LO write enable
mem_op_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
mem_addr_i  in  ADDR_W  effective address
store_data_i  in  32  rt value for stores
wdata_o  out  32  GPR write data to WB
wd_o  out  5  destination register to WB
wreg_o  out  1  GPR write enable to WB
hi_o  out  32  HI to WB
lo_o  out  32  LO to WB
whilo_o  out  1  HI/LO write enable to WB
daddr_o  out  ADDR_W  word-aligned bus address ({mem_addr_i[ADDR_W-1:2],2'b00})
dwdata_o  out  32  store data replicated to lanes
dbe_o  out  4  byte enables; bit3 = bits 31:24 = byte address 0
dwe_o  out  1  1 = write
dreq_o  out  1  bus request
dack_i  in  1  bus acknowledge; dack_i is the data-valid strobe for reads
drdata_i  in  32  read data, valid with dack_i
stall_req_o  out  1  hold pipeline upstream (including the EX/MEM register)
adel_o  out  1  address error on load (misaligned)
ades_o  out  1  address error on store (misaligned)
bus_err_o  out  1  access timed out

Behaviour:
- Reset:
  - rst is synchronous, active-high.
  - On reset: state IDLE, timeout counter 0, captured-data register 0.
  - During rst all outputs read 0: wd_o 0, enables 0, dreq_o 0, stall_req_o 0, all exception flags 0.
  - Reset mid-access drops dreq_o the same edge; the outstanding ack is ignored.
- Alignment:
  - Halfword ops require addr[0]=0; word ops require addr[1:0]=0; byte ops are always aligned.
  - A misaligned op issues no request and no stall.
  - It raises adel_o (load) or ades_o (store) combinationally in IDLE.
  - It forces wreg_o=0 and whilo_o=0.
- Non-memory op (mem_op none) in IDLE:
  - Zero-latency combinational passthrough of wdata, wd, wreg, hi, lo and whilo.
  - dreq_o=0, stall_req_o=0.
- FSM IDLE:
  - Aligned memory op: dreq_o=1 and stall_req_o=1 combinationally, counter cleared; go to WAIT.
- FSM WAIT:
  - dreq_o=1 and stall_req_o=1; bus outputs held stable.
  - Counter increments each cycle.
  - dack_i=1: capture drdata_i, go to DONE (ack in the same cycle as the counter reaching TIMEOUT takes priority over the timeout).
  - Counter==TIMEOUT without ack: set the error flag, go to DONE.
- FSM DONE (exactly one cycle):
  - dreq_o=0, stall_req_o=0; the pipeline advances at the end of this cycle; next state IDLE.
  - Loads: wdata_o = extended captured data, wreg_o = wreg_i.
  - Stores: wreg_o = wreg_i, passthrough.
  - bus_err_o=1 for this cycle only if timed out; a timed-out access forces wreg_o=0 and whilo_o=0.
  - HI/LO outputs pass through in DONE.
- Minimum latency: a load acked in its first WAIT cycle completes with 2 stall cycles plus 1 DONE cycle.
- Load lane select (big-endian):
  - Byte: lane = addr[1:0], with lane 0 = bits 31:24. LB sign-extends bit 7 of the selected byte; LBU zero-extends.
  - Halfword: addr[1]=0 selects bits 31:16, else bits 15:0. LH sign-extends; LHU zero-extends.
  - LW takes the word unchanged.
- Store lanes:
  - SB: dwdata_o = byte replicated ×4; dbe_o = 4'b1000 >> addr[1:0].
  - SH: dwdata_o = halfword replicated ×2; dbe_o = 1100 or 0011.
  - SW: dbe_o = 1111.
  - Loads drive dbe_o = 1111 and dwe_o=0.
- When dreq_o=0: daddr_o, dwdata_o and dbe_o are 0.
- Stall interface: inputs are stable while stall_req_o=1. Any dack_i arriving in IDLE or DONE is ignored.

Test Plan:
1. Passthrough: mem_op=0, wdata_i=0x12345678, wd_i=5, wreg_i=1, whilo_i=1 -> same values out the same cycle, dreq_o=0, stall_req_o=0.
2. LB sign: addr=0x1001, memory word 0x11AA2233, dack_i on 1st WAIT cycle -> dbe_o=1111, stall high 2 cycles, DONE wdata_o=0xFFFFFFAA; LBU same stimulus -> 0x000000AA.
3. SH at addr=0x2002, store_data=0xDEADBEEF, dack_i after 3 wait cycles -> dbe_o=0011, dwdata_o=0xBEEFBEEF, dwe_o=1, stall held 4 cycles.
4. Misaligned: LW at 0x3002 -> adel_o=1, wreg_o=0, dreq_o=0; SW at 0x3001 -> ades_o=1, no request.
5. Timeout with TIMEOUT=4 and no ack -> dreq_o high 5 cycles (IDLE + 4 WAIT), then bus_err_o=1 for 1 cycle with wreg_o=0; ack arriving on the counter==4 cycle -> normal completion, bus_err_o=0.
6. rst asserted during WAIT -> next cycle dreq_o=0, stall_req_o=0, state IDLE; subsequent LHU at 0x0 of 0x8001xxxx -> 0x00008001.
